tri_bus_reader: RTL and testbench



---
 rtl/tri_bus_reader.sv | 168 ++++++++++++++++
 tb/tb_tri_bus_reader.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tri_bus_reader.sv
// Round-robin reader for a shared tri-state bus: one grant at a time with an idle turnaround cycle,
// captured words queued with their source index. Define TRI_BUS_REQCHK_EN to add the oErr abort check.
module tri_bus_reader #(
    parameter int unsigned N_SRC = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned SW = $clog2(N_SRC)
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic [N_SRC-1:0] iReq,
    output logic [N_SRC-1:0] oEna,
    input  logic [WIDTH-1:0] iBus,
    output logic [N_SRC-1:0] oAck,
    output logic [WIDTH-1:0] oData,
    output logic [SW-1:0]    oSrc,
    output logic             oValid,
    input  logic             iReady,
    output logic             oFull
`ifdef TRI_BUS_REQCHK_EN
    ,
    output logic             oErr
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = SW + WIDTH;

    typedef enum logic [1:0] {StIdle, StSettle, StCapture} state_e;

    state_e           state_q, state_d;
    logic [N_SRC-1:0] ena_q, ena_d;
    logic [SW-1:0]    grant_q, grant_d;
    logic [SW-1:0]    last_q, last_d;
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [EW-1:0]    mem_q [DEPTH];
    logic [EW-1:0]    mem_d [DEPTH];

    logic [SW-1:0]    cand;
    logic [SW-1:0]    pick;
    logic             pick_vld;
    logic             req_lost;
    logic             push;
    logic             pop;

`ifdef TRI_BUS_REQCHK_EN
    logic err_q, err_d;

    // The granted source gave up its request before the word was taken.
    assign req_lost = (state_q != StIdle) && !iReq[grant_q];
    assign err_d    = err_q | req_lost;
    assign oErr     = err_q;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`else
    assign req_lost = 1'b0;
`endif

    // First requester strictly after the last grant, wrapping around.
    always_comb begin
        cand     = '0;
        pick     = '0;
        pick_vld = 1'b0;
        for (int unsigned i = 1; i <= N_SRC; i++) begin
            cand = SW'((32'(last_q) + i) % N_SRC);
            if (!pick_vld && iReq[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ena_d   = ena_q;
        grant_d = grant_q;
        last_d  = last_q;
        oAck    = '0;
        push    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pick_vld && (cnt_q < CW'(DEPTH))) begin
                    ena_d       = '0;
                    ena_d[pick] = 1'b1;
                    grant_d     = pick;
                    last_d      = pick;
                    state_d     = StSettle;
                end
            end
            StSettle: begin
                if (req_lost) begin
                    ena_d   = '0;
                    state_d = StIdle;
                end else begin
                    state_d = StCapture;
                end
            end
            StCapture: begin
                if (!req_lost) begin
                    oAck[grant_q] = 1'b1;
                    push          = 1'b1;
                end
                ena_d   = '0;
                state_d = StIdle;
            end
            default: begin
                ena_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    assign oValid = (cnt_q != '0);
    assign oFull  = (cnt_q == CW'(DEPTH));
    assign pop    = oValid && iReady;

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push) begin
            mem_d[wptr_q] = {grant_q, iBus};
            wptr_d        = wptr_q + AW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        cnt_d = cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= StIdle;
            ena_q   <= '0;
            grant_q <= '0;
            last_q  <= SW'(N_SRC - 1);
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ena_q   <= ena_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            mem_q   <= mem_d;
        end
    end

    assign oEna  = ena_q;
    assign oData = mem_q[rptr_q][WIDTH-1:0];
    assign oSrc  = mem_q[rptr_q][EW-1:WIDTH];

endmodule

// File: tb/tb_tri_bus_reader.sv
// Self-checking bench for tri_bus_reader: per-scenario tasks against a transaction-level
// round-robin / FIFO reference model, with randomized request and consumer traffic.
module tb_tri_bus_reader;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int D  = 4;
    localparam int SW = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] ena;
    logic [N-1:0] ack;
    logic [W-1:0] bus;
    logic [W-1:0] odata;
    logic [SW-1:0] osrc;
    logic         valid;
    logic         full;
    logic         ready = 1'b0;
`ifdef TRI_BUS_REQCHK_EN
    logic         err;
`endif

    logic [W-1:0] src_data [N];

    tri_bus_reader #(.N_SRC(N), .WIDTH(W), .DEPTH(D)) dut (
        .iClk   (clk),
        .iRst_n (rst_n),
        .iReq   (req),
        .oEna   (ena),
        .iBus   (bus),
        .oAck   (ack),
        .oData  (odata),
        .oSrc   (osrc),
        .oValid (valid),
        .iReady (ready),
        .oFull  (full)
`ifdef TRI_BUS_REQCHK_EN
        ,
        .oErr   (err)
`endif
    );

    always #5 clk = ~clk;

    // Resolved bus: whichever gate is enabled drives its source word.
    always_comb begin
        bus = '0;
        for (int i = 0; i < N; i++) if (ena[i]) bus = bus | src_data[i];
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model and observation state.
    int              last_m;
    int              mcount;
    int              grants_q[$];
    logic [SW+W-1:0] expq[$];
    logic [SW+W-1:0] popped_q[$];
    logic [N-1:0]    ena_prev;
    int              ena_len;
    int              ena_cycles, ack_cycles;
    int              n_multihot, n_nogap, n_badack, n_rrbad, n_fullgrant, n_badlen, n_fifobad;
    bit              auto_drop;
    bit              allow_abort;

    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        int idx;
        for (int i = 1; i <= N; i++) begin
            idx = (last + i) % N;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic reset_model();
        last_m = N - 1; mcount = 0;
        grants_q.delete(); expq.delete(); popped_q.delete();
        ena_prev = '0; ena_len = 0; ena_cycles = 0; ack_cycles = 0;
        n_multihot = 0; n_nogap = 0; n_badack = 0; n_rrbad = 0;
        n_fullgrant = 0; n_badlen = 0; n_fifobad = 0;
        allow_abort = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = '0; ready = 1'b0; auto_drop = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        reset_model();
    endtask

    // One clock: record what the model predicts and what the DUT shows; judged by the tests.
    task automatic step();
        logic [N-1:0] req_e, ack_e;
        logic         pop_e;
        int           cnt_e, g, exp_g;
        req_e = req; ack_e = ack; pop_e = valid && ready; cnt_e = mcount;
        if (pop_e) popped_q.push_back({osrc, odata});
        @(posedge clk);
        #1;
        if (auto_drop) req = req & ~ack_e;
        mcount = mcount + ((ack_e != '0) ? 1 : 0) - (pop_e ? 1 : 0);
        @(negedge clk);
        if (!$onehot0(ena)) n_multihot++;
        if (ena_prev != '0 && ena != '0 && ena != ena_prev) n_nogap++;
        if (ack != '0 && (ack != ena || ena_prev != ena)) n_badack++;
        if (!allow_abort && ena != '0 && ena == ena_prev && ack == '0) n_badack++;
        if (ena != '0 && ena_prev == '0) begin
            g = 0;
            for (int i = 0; i < N; i++) if (ena[i]) g = i;
            exp_g = rr_pick(req_e, last_m);
            if (g != exp_g) n_rrbad++;
            if (cnt_e >= D) n_fullgrant++;
            last_m = g;
            grants_q.push_back(g);
            expq.push_back({g[SW-1:0], src_data[g]});
            ena_len = 0;
        end
        if (ena != '0) begin ena_len++; ena_cycles++; end
        if (ack != '0) ack_cycles++;
        if (ena == '0 && ena_prev != '0) begin
            if (!allow_abort && ena_len != 2) n_badlen++;
            ena_len = 0;
        end
        if (valid !== (mcount != 0) || full !== (mcount == D)) n_fifobad++;
        ena_prev = ena;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_tests++; if (ena !== '0) begin n_fail++; $display("FAIL reset_ena got %h want 0", ena); end
        n_tests++; if (ack !== '0) begin n_fail++; $display("FAIL reset_ack got %h want 0", ack); end
        n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid); end
        n_tests++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", full); end
        n_tests++; if (odata !== '0) begin n_fail++; $display("FAIL reset_data got %h want 0", odata); end
        n_tests++; if (osrc !== '0) begin n_fail++; $display("FAIL reset_src got %h want 0", osrc); end
`ifdef TRI_BUS_REQCHK_EN
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
`endif
    endtask

    task automatic test_single();
        do_reset();
        src_data[0] = 8'hA5;
        req = 4'b0001;
        for (int i = 0; i < 12; i++) step();
        n_tests++; if (grants_q.size() != 1) begin n_fail++; $display("FAIL single_grants got %0d want 1", grants_q.size()); end
        n_tests++; if (ena_cycles != 2) begin n_fail++; $display("FAIL single_ena_cycles got %0d want 2", ena_cycles); end
        n_tests++; if (ack_cycles != 1) begin n_fail++; $display("FAIL single_ack_cycles got %0d want 1", ack_cycles); end
        n_tests++; if (n_badack != 0) begin n_fail++; $display("FAIL single_ack_timing got %0d want 0", n_badack); end
        n_tests++; if (valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", valid); end
        n_tests++; if (odata !== 8'hA5) begin n_fail++; $display("FAIL single_data got %h want a5", odata); end
        n_tests++; if (osrc !== 2'd0) begin n_fail++; $display("FAIL single_src got %0d want 0", osrc); end
        ready = 1'b1; step(); ready = 1'b0;
        n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL single_pop_valid got %b want 0", valid); end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] pend;
        int           last, g;
        do_reset();
        for (int i = 0; i < N; i++) src_data[i] = 8'($urandom);
        req = 4'b1111; ready = 1'b1;
        for (int i = 0; i < 20; i++) step();
        n_tests++; if (grants_q.size() != N) begin n_fail++; $display("FAIL rr_grants got %0d want %0d", grants_q.size(), N); end
        pend = 4'b1111; last = N - 1;
        for (int k = 0; k < N && k < grants_q.size(); k++) begin
            g = rr_pick(pend, last); pend[g] = 1'b0; last = g;
            n_tests++; if (grants_q[k] != g) begin n_fail++; $display("FAIL rr_order[%0d] got %0d want %0d", k, grants_q[k], g); end
        end
        n_tests++; if (n_multihot != 0) begin n_fail++; $display("FAIL rr_multihot got %0d want 0", n_multihot); end
        n_tests++; if (n_nogap != 0) begin n_fail++; $display("FAIL rr_turnaround got %0d want 0", n_nogap); end
        n_tests++; if (popped_q.size() != N) begin n_fail++; $display("FAIL rr_popped got %0d want %0d", popped_q.size(), N); end
        for (int k = 0; k < popped_q.size() && k < expq.size(); k++) begin
            n_tests++; if (popped_q[k] !== expq[k]) begin n_fail++; $display("FAIL rr_word[%0d] got %h want %h", k, popped_q[k], expq[k]); end
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < N; i++) src_data[i] = 8'($urandom);
        auto_drop = 0; req = 4'b1111; ready = 1'b0;
        for (int i = 0; i < 30; i++) step();
        n_tests++; if (grants_q.size() != D) begin n_fail++; $display("FAIL full_grants got %0d want %0d", grants_q.size(), D); end
        n_tests++; if (full !== 1'b1) begin n_fail++; $display("FAIL full_flag got %b want 1", full); end
        n_tests++; if (n_fullgrant != 0) begin n_fail++; $display("FAIL full_grant_when_full got %0d want 0", n_fullgrant); end
        ready = 1'b1; step(); ready = 1'b0;
        for (int i = 0; i < 6; i++) step();
        n_tests++; if (popped_q.size() != 1) begin n_fail++; $display("FAIL full_pops got %0d want 1", popped_q.size()); end
        else begin
            n_tests++; if (popped_q[0] !== expq[0]) begin n_fail++; $display("FAIL full_head got %h want %h", popped_q[0], expq[0]); end
        end
        n_tests++; if (grants_q.size() != D + 1) begin n_fail++; $display("FAIL full_regrant got %0d want %0d", grants_q.size(), D + 1); end
        n_tests++; if (n_rrbad != 0 || n_fifobad != 0) begin n_fail++; $display("FAIL full_model got rr=%0d fifo=%0d want 0", n_rrbad, n_fifobad); end
        n_tests++; if (full !== 1'b1) begin n_fail++; $display("FAIL full_refill got %b want 1", full); end
    endtask

    task automatic test_push_pop();
        bit seen;
        do_reset();
        for (int i = 0; i < N; i++) src_data[i] = 8'($urandom);
        req = 4'b0011;
        for (int i = 0; i < 10; i++) step();
        req[2] = 1'b1;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin step(); seen = ack[2]; end
        n_tests++; if (!seen) begin n_fail++; $display("FAIL pp_ack2 got 0 want 1"); end
        ready = 1'b1; step(); ready = 1'b0;
        n_tests++; if (valid !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL pp_flags got v=%b f=%b want v=1 f=0", valid, full); end
        ready = 1'b1;
        for (int i = 0; i < 10 && valid; i++) step();
        ready = 1'b0;
        n_tests++; if (popped_q.size() != 3) begin n_fail++; $display("FAIL pp_count got %0d want 3", popped_q.size()); end
        for (int k = 0; k < popped_q.size() && k < expq.size(); k++) begin
            n_tests++; if (popped_q[k] !== expq[k]) begin n_fail++; $display("FAIL pp_word[%0d] got %h want %h", k, popped_q[k], expq[k]); end
        end
        n_tests++; if (n_fifobad != 0) begin n_fail++; $display("FAIL pp_occupancy got %0d want 0", n_fifobad); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            ready = 1'($urandom_range(0, 1));
            for (int i = 0; i < N; i++) begin
                if (!req[i] && !ena[i] && $urandom_range(0, 3) == 0) begin
                    src_data[i] = 8'($urandom);
                    req[i] = 1'b1;
                end
            end
            step();
        end
        ready = 1'b1;
        for (int c = 0; c < 100; c++) step();
        n_tests++; if (grants_q.size() < 20) begin n_fail++; $display("FAIL rnd_activity got %0d want >=20", grants_q.size()); end
        n_tests++; if (popped_q.size() != expq.size()) begin n_fail++; $display("FAIL rnd_count got %0d want %0d", popped_q.size(), expq.size()); end
        for (int k = 0; k < popped_q.size() && k < expq.size(); k++) begin
            n_tests++; if (popped_q[k] !== expq[k]) begin n_fail++; $display("FAIL rnd_word[%0d] got %h want %h", k, popped_q[k], expq[k]); end
        end
        n_tests++;
        if (n_rrbad + n_multihot + n_nogap + n_fifobad + n_fullgrant + n_badlen + n_badack != 0) begin
            n_fail++;
            $display("FAIL rnd_protocol got rr=%0d mh=%0d gap=%0d fifo=%0d fg=%0d len=%0d ack=%0d want 0",
                     n_rrbad, n_multihot, n_nogap, n_fifobad, n_fullgrant, n_badlen, n_badack);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < N; i++) src_data[i] = 8'($urandom);
        req = 4'b0001;
        for (int i = 0; i < 6; i++) step();
        req = 4'b0010;
        for (int i = 0; i < 5 && ena == '0; i++) step();
        n_tests++; if (ena !== 4'b0010) begin n_fail++; $display("FAIL rm_settle got %h want 2", ena); end
        rst_n = 1'b0;
        #1;
        n_tests++; if (ena !== '0) begin n_fail++; $display("FAIL rm_ena got %h want 0", ena); end
        n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rm_valid got %b want 0", valid); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        reset_model();
        req = 4'b1111; ready = 1'b1;
        for (int i = 0; i < 8; i++) step();
        n_tests++; if (grants_q.size() == 0 || grants_q[0] != 0) begin n_fail++; $display("FAIL rm_first got %0d want 0", (grants_q.size() == 0) ? -1 : grants_q[0]); end
    endtask

`ifdef TRI_BUS_REQCHK_EN
    task automatic test_err();
        do_reset();
        allow_abort = 1;
        req = 4'b0010;
        for (int i = 0; i < 5 && ena == '0; i++) step();
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_pre got %b want 0", err); end
        req[1] = 1'b0;
        step();
        n_tests++; if (ena !== '0) begin n_fail++; $display("FAIL err_ena got %h want 0", ena); end
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_set got %b want 1", err); end
        req = 4'b0001;
        for (int i = 0; i < 8; i++) step();
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b want 1", err); end
        n_tests++; if (popped_q.size() != 0 || mcount != 1) begin n_fail++; $display("FAIL err_nopush got pops=%0d cnt=%0d want 0/1", popped_q.size(), mcount); end
        n_tests++; if (n_fifobad != 0) begin n_fail++; $display("FAIL err_occupancy got %0d want 0", n_fifobad); end
    endtask
`endif

    initial begin
        for (int i = 0; i < N; i++) src_data[i] = '0;
        auto_drop = 1;
        reset_model();
        test_reset();
        test_single();
        test_round_robin();
        test_full();
        test_push_pop();
        test_random();
        test_reset_mid();
`ifdef TRI_BUS_REQCHK_EN
        test_err();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
